mc_control_fsm: RTL and testbench

- Multi-cycle control unit for the RV32I core. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB over a shared memory port with a ready handshake.
- Emits per-state datapath enables plus the registered 10-bit control word.
- Adds illegal-opcode handling, a memory-timeout watchdog and a retired-instruction counter.
- Sits between the IR/PC datapath and the unified memory interface.

---
 rtl/cu_pkg.sv | 67 ++++++
 rtl/opcode_decoder.sv | 33 +++
 rtl/mc_control_fsm.sv | 158 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and encodings for the RV32I multi-cycle control unit.
package cu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_IALU   = 5'b00100;

    localparam int CB_IMM_SEL   = 9;
    localparam int CB_MEM_READ  = 8;
    localparam int CB_MEM_WRITE = 7;
    localparam int CB_TO_REG_HI = 6;
    localparam int CB_TO_REG_LO = 5;
    localparam int CB_ALU_OP_HI = 4;
    localparam int CB_ALU_OP_LO = 3;
    localparam int CB_ALU_SRC1  = 2;
    localparam int CB_ALU_SRC2  = 1;
    localparam int CB_REG_WRITE = 0;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] TR_PC4   = 2'b00;
    localparam logic [1:0] TR_ALU   = 2'b01;
    localparam logic [1:0] TR_MEM   = 2'b10;
    localparam logic [1:0] TR_PCIMM = 2'b11;

    localparam logic [9:0] ILLEGAL_CTRL = 10'b0;
    localparam logic [9:0] CTRL_R      = 10'b0_0_0_01_10_0_0_1;
    localparam logic [9:0] CTRL_LOAD   = 10'b0_1_0_10_00_0_1_1;
    localparam logic [9:0] CTRL_STORE  = 10'b0_0_1_00_00_0_1_0;
    localparam logic [9:0] CTRL_BRANCH = 10'b0_0_0_00_01_0_1_0;
    localparam logic [9:0] CTRL_LUI    = 10'b0_0_0_01_11_0_1_1;
    localparam logic [9:0] CTRL_AUIPC  = 10'b0_0_0_11_00_1_1_1;
    localparam logic [9:0] CTRL_JAL    = 10'b0_0_0_00_00_1_1_1;
    localparam logic [9:0] CTRL_JALR   = 10'b0_0_0_00_00_0_1_1;
    localparam logic [9:0] CTRL_IALU   = 10'b0_0_0_01_10_0_1_1;

    // Instruction class is recovered from the control word so only ctrl_q needs to be kept.
    function automatic logic is_mem(input logic [9:0] c);
        return c[CB_MEM_READ] | c[CB_MEM_WRITE];
    endfunction

    function automatic logic is_branch(input logic [9:0] c);
        return c[CB_ALU_OP_HI:CB_ALU_OP_LO] == 2'b01;
    endfunction

    function automatic logic is_jump(input logic [9:0] c);
        return c[CB_REG_WRITE] && c[CB_TO_REG_HI:CB_TO_REG_LO] == TR_PC4;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: maps the RV32I major opcode to a 10-bit control word and an illegal flag.
module opcode_decoder
    import cu_pkg::*;
(
    input  logic [6:0] instr_i,
    output logic [9:0] ctrl_o,
    output logic       illegal_o
);

    logic [9:0] code;
    logic       known;

    always_comb begin
        code  = ILLEGAL_CTRL;
        known = 1'b1;
        case (instr_i[6:2])
            OP_R:      code = CTRL_R;
            OP_LOAD:   code = CTRL_LOAD;
            OP_STORE:  code = CTRL_STORE;
            OP_BRANCH: code = CTRL_BRANCH;
            OP_LUI:    code = CTRL_LUI;
            OP_AUIPC:  code = CTRL_AUIPC;
            OP_JAL:    code = CTRL_JAL;
            OP_JALR:   code = CTRL_JALR;
            OP_IALU:   code = CTRL_IALU;
            default:   known = 1'b0;
        endcase
    end

    assign illegal_o = !known || instr_i[1:0] != 2'b11;
    assign ctrl_o    = illegal_o ? ILLEGAL_CTRL : code;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with
// illegal-opcode handling, memory watchdog and retired-instruction counter.
module mc_control_fsm
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT         = 0,
    parameter int unsigned TIMEOUT_W       = 8,
    parameter bit          HALT_ON_ILLEGAL = 1'b1,
    parameter int unsigned RET_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             mem_ready_i,
    input  logic             br_taken_i,
    output logic [9:0]       ctrl_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             addr_sel_o,
    output logic             reg_we_o,
    output logic [1:0]       to_reg_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic             halted_o,
    output logic [RET_W-1:0] instret_o,
    output logic [2:0]       state_o
);

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [9:0]           ctrl_q, ctrl_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic [RET_W-1:0]     instret_q, instret_d;
    logic                 illegal_q, illegal_d;
    logic                 bus_err_q, bus_err_d;
    logic                 run_q, run_d;
    logic [9:0]           dec_ctrl;
    logic                 dec_illegal;
    logic                 retire;
    logic                 timeout;
    logic                 unused_instr;

    assign unused_instr = ^instr_i[31:7];

    opcode_decoder u_dec (
        .instr_i   (instr_i[6:0]),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // run_q holds every strobe low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= '0;
            wd_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            wd_q      <= wd_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            run_q     <= run_d;
        end
    end

    assign timeout = TIMEOUT != 0 && mem_req_o && !mem_ready_i && wd_q == WD_LAST;

    always_comb begin
        state_d = state_q;
        if (run_q) begin
            case (state_q)
                S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
                S_DECODE: state_d = !dec_illegal ? S_EXEC : (HALT_ON_ILLEGAL ? S_HALT : S_FETCH);
                S_EXEC:   state_d = is_mem(ctrl_q) ? S_MEM :
                                    (is_branch(ctrl_q) || is_jump(ctrl_q)) ? S_FETCH : S_WB;
                S_MEM:    state_d = !mem_ready_i ? S_MEM : (ctrl_q[CB_MEM_READ] ? S_WB : S_FETCH);
                S_WB:     state_d = S_FETCH;
                default:  state_d = S_HALT;
            endcase
            if (timeout)
                state_d = S_HALT;
        end
    end

    always_comb begin
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_src_o   = PC_PLUS4;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        addr_sel_o = 1'b0;
        reg_we_o   = 1'b0;
        to_reg_o   = TR_PC4;
        retire     = 1'b0;
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    ir_we_o   = mem_ready_i;
                end
                S_DECODE: pc_we_o = dec_illegal && !HALT_ON_ILLEGAL;
                S_EXEC: begin
                    if (is_branch(ctrl_q)) begin
                        pc_we_o  = 1'b1;
                        pc_src_o = br_taken_i ? PC_IMM : PC_PLUS4;
                        retire   = 1'b1;
                    end else if (is_jump(ctrl_q)) begin
                        reg_we_o = 1'b1;
                        pc_we_o  = 1'b1;
                        pc_src_o = ctrl_q[CB_ALU_SRC1] ? PC_IMM : PC_ALU;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = ctrl_q[CB_MEM_WRITE];
                    pc_we_o    = mem_ready_i && !ctrl_q[CB_MEM_READ];
                    retire     = pc_we_o;
                end
                S_WB: begin
                    reg_we_o = 1'b1;
                    to_reg_o = ctrl_q[CB_TO_REG_HI:CB_TO_REG_LO];
                    pc_we_o  = 1'b1;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        run_d     = 1'b1;
        ctrl_d    = (run_q && state_q == S_DECODE) ? dec_ctrl : ctrl_q;
        illegal_d = illegal_q | (run_q && state_q == S_DECODE && dec_illegal);
        bus_err_d = bus_err_q | timeout;
        instret_d = instret_q + RET_W'(retire);
        wd_d      = (mem_req_o && !mem_ready_i && state_d == state_q) ? wd_q + 1'b1 : '0;
    end

    assign ctrl_o    = ctrl_q;
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
    assign halted_o  = state_q == S_HALT;
    assign instret_o = instret_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed checks on two configurations, one with watchdog and
// halt-on-illegal, one with watchdog disabled and skip-on-illegal.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n, ready, br;
    logic [31:0] instr;
    logic [9:0]  a_ctrl;
    logic        a_ir_we, a_pc_we, a_mem_req, a_mem_we, a_addr_sel, a_reg_we;
    logic [1:0]  a_pc_src, a_to_reg;
    logic        a_illegal, a_bus_err, a_halted;
    logic [31:0] a_instret;
    logic [2:0]  a_state;

    logic        b_rst_n, b_ready;
    logic [31:0] b_instr;
    logic [9:0]  b_ctrl;
    logic        b_ir_we, b_pc_we, b_mem_req, b_mem_we, b_addr_sel, b_reg_we;
    logic [1:0]  b_pc_src, b_to_reg;
    logic        b_illegal, b_bus_err, b_halted;
    logic [31:0] b_instret;
    logic [2:0]  b_state;

    int checks = 0;
    int errors = 0;

    mc_control_fsm #(.TIMEOUT(4), .TIMEOUT_W(8), .HALT_ON_ILLEGAL(1'b1), .RET_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .mem_ready_i(ready), .br_taken_i(br),
        .ctrl_o(a_ctrl), .ir_we_o(a_ir_we), .pc_we_o(a_pc_we), .pc_src_o(a_pc_src),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .addr_sel_o(a_addr_sel),
        .reg_we_o(a_reg_we), .to_reg_o(a_to_reg), .illegal_o(a_illegal),
        .bus_err_o(a_bus_err), .halted_o(a_halted), .instret_o(a_instret), .state_o(a_state)
    );

    mc_control_fsm #(.TIMEOUT(0), .TIMEOUT_W(8), .HALT_ON_ILLEGAL(1'b0), .RET_W(32)) u_b (
        .clk(clk), .rst_n(b_rst_n), .instr_i(b_instr), .mem_ready_i(b_ready), .br_taken_i(1'b0),
        .ctrl_o(b_ctrl), .ir_we_o(b_ir_we), .pc_we_o(b_pc_we), .pc_src_o(b_pc_src),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .addr_sel_o(b_addr_sel),
        .reg_we_o(b_reg_we), .to_reg_o(b_to_reg), .illegal_o(b_illegal),
        .bus_err_o(b_bus_err), .halted_o(b_halted), .instret_o(b_instret), .state_o(b_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; br = 1'b0; instr = '0;
        b_rst_n = 1'b0; b_ready = 1'b0; b_instr = '0;
        tick();
        tick();
        chk("rst_state", a_state, 0);
        chk("rst_req", a_mem_req, 0);
        chk("rst_instret", a_instret, 0);
        chk("rst_ctrl", a_ctrl, 0);
        chk("rst_flags", {a_illegal, a_bus_err, a_halted}, 0);
        rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        chk("pre_run_req", a_mem_req, 0);
        tick();
        chk("fetch_req", {a_mem_req, a_addr_sel, a_ir_we}, 3'b100);

        // addi x1,x0,5
        instr = 32'h00500093; ready = 1'b1;
        #1;
        chk("addi_ir_we", a_ir_we, 1);
        tick();
        ready = 1'b0;
        #1;
        chk("addi_decode", {a_state, a_mem_req, a_ir_we}, {3'd1, 2'b00});
        tick();
        chk("addi_exec", a_state, 2);
        chk("addi_ctrl", a_ctrl, 10'h033);
        tick();
        chk("addi_wb", {a_state, a_reg_we, a_to_reg, a_pc_we, a_pc_src}, {3'd4, 1'b1, 2'b01, 1'b1, 2'b00});
        chk("addi_instret_pre", a_instret, 0);
        tick();
        chk("addi_fetch", a_state, 0);
        chk("addi_instret", a_instret, 1);

        // lw x2,0(x1), ready arrives on the 4th MEM cycle (watchdog boundary)
        instr = 32'h0000A103; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        chk("lw_ctrl", a_ctrl, 10'h143);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", {a_state, a_mem_req, a_addr_sel, a_mem_we, a_reg_we}, {3'd3, 4'b1100});
            tick();
        end
        ready = 1'b1;
        #1;
        chk("lw_mem_ready", {a_state, a_mem_req, a_pc_we, a_bus_err}, {3'd3, 3'b100});
        tick();
        ready = 1'b0;
        #1;
        chk("lw_wb", {a_state, a_reg_we, a_to_reg}, {3'd4, 1'b1, 2'b10});
        tick();
        chk("lw_instret", a_instret, 2);
        chk("lw_no_buserr", {a_bus_err, a_state}, 4'd0);

        // sw x2,0(x1)
        instr = 32'h0020A023; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        chk("sw_ctrl", a_ctrl, 10'h082);
        tick();
        chk("sw_mem_wait", {a_state, a_mem_we, a_reg_we, a_pc_we}, {3'd3, 3'b100});
        ready = 1'b1;
        #1;
        chk("sw_mem_ready", {a_mem_we, a_reg_we, a_pc_we, a_pc_src}, 5'b10100);
        tick();
        ready = 1'b0;
        #1;
        chk("sw_retire", {a_state, a_instret}, {3'd0, 32'd3});

        // beq taken
        instr = 32'h00000463; ready = 1'b1;
        tick();
        ready = 1'b0; br = 1'b1;
        tick();
        chk("beq_exec", {a_state, a_pc_we, a_pc_src, a_reg_we}, {3'd2, 1'b1, 2'b01, 1'b0});
        tick();
        br = 1'b0;
        chk("beq_retire", {a_state, a_instret}, {3'd0, 32'd4});

        // illegal opcode halts
        instr = 32'h00000000; ready = 1'b1;
        tick();
        ready = 1'b0;
        #1;
        chk("ill_decode_pcwe", a_pc_we, 0);
        tick();
        ready = 1'b1;
        #1;
        chk("ill_halt", {a_state, a_illegal, a_halted}, {3'd5, 2'b11});
        chk("ill_strobes", {a_mem_req, a_ir_we, a_pc_we, a_reg_we, a_mem_we}, 0);
        tick();
        tick();
        chk("ill_stays", {a_state, a_instret}, {3'd5, 32'd4});
        ready = 1'b0;

        // watchdog expiry in FETCH
        rst_n = 1'b0;
        tick();
        chk("rst2_flags", {a_illegal, a_halted, a_instret}, 0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("wd_last_cycle", {a_state, a_mem_req, a_bus_err}, {3'd0, 2'b10});
        tick();
        chk("wd_expired", {a_state, a_bus_err, a_halted, a_mem_req}, {3'd5, 3'b110});

        // reset during a MEM wait
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        instr = 32'h00500093; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        tick();
        instr = 32'h0000A103; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        tick();
        chk("mid_mem_pre", {a_state, a_mem_req, a_instret}, {3'd3, 1'b1, 32'd1});
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_mem_abort", {a_mem_req, a_addr_sel, a_state}, 5'b00000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst", {a_state, a_instret, a_illegal, a_bus_err}, 0);
        chk("post_rst_req", a_mem_req, 1);

        // second instance: no watchdog, skip illegal
        chk("b_no_watchdog", {b_state, b_bus_err, b_mem_req}, {3'd0, 2'b01});
        b_instr = 32'h00000000; b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        #1;
        chk("b_ill_skip", {b_state, b_pc_we, b_pc_src}, {3'd1, 1'b1, 2'b00});
        tick();
        chk("b_ill_back", {b_state, b_illegal, b_halted, b_instret}, {3'd0, 2'b10, 32'd0});
        chk("b_ill_ctrl", b_ctrl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
